// File: rtl/csi_packet_parser.sv
// Single-lane CSI-2 packet parser: header ECC check, short-packet decode, payload streaming with CRC-16.
// Latency: outputs one cycle after the consuming byte; no backpressure (enable-driven), phy_reset one cycle after packet end.
module csi_packet_parser #(
    parameter bit CHECK_ECC = 1'b1,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clock_p,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        enable,
    output logic        phy_reset,
    output logic [1:0]  virtual_channel,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        header_valid,
    output logic        ecc_error,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic        crc_error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_FOOTER  = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;

    logic [2:0]  r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [15:0] r_cnt;
    logic [15:0] r_crc;
    logic [7:0]  r_crc_lo;
    logic        r_ftr_idx;

    logic [23:0] w_hdr;
    logic [5:0]  w_ecc_calc;
    logic [5:0]  w_syndrome;
    logic        w_hdr_ok;
    logic        w_short;
    logic [15:0] w_wc;
    logic [15:0] w_crc_next;

    // CRC-16/CCITT, reflected form: bits enter LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb    = r[0] ^ d[i];
            r     = {fb, r[15:1]};
            r[10] = r[10] ^ fb;
            r[3]  = r[3] ^ fb;
        end
        return r;
    endfunction

    assign w_hdr = {r_b2, r_b1, r_b0};
    assign w_ecc_calc[0] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[4]  ^ w_hdr[5]  ^ w_hdr[7]  ^ w_hdr[10]
                         ^ w_hdr[11] ^ w_hdr[13] ^ w_hdr[16] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc_calc[1] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[3]  ^ w_hdr[4]  ^ w_hdr[6]  ^ w_hdr[8]  ^ w_hdr[10]
                         ^ w_hdr[12] ^ w_hdr[14] ^ w_hdr[17] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc_calc[2] = w_hdr[0]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[5]  ^ w_hdr[6]  ^ w_hdr[9]  ^ w_hdr[11]
                         ^ w_hdr[12] ^ w_hdr[15] ^ w_hdr[18] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22];
    assign w_ecc_calc[3] = w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[7]  ^ w_hdr[8]  ^ w_hdr[9]  ^ w_hdr[13]
                         ^ w_hdr[14] ^ w_hdr[15] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[23];
    assign w_ecc_calc[4] = w_hdr[4]  ^ w_hdr[5]  ^ w_hdr[6]  ^ w_hdr[7]  ^ w_hdr[8]  ^ w_hdr[9]  ^ w_hdr[16]
                         ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc_calc[5] = w_hdr[10] ^ w_hdr[11] ^ w_hdr[12] ^ w_hdr[13] ^ w_hdr[14] ^ w_hdr[15] ^ w_hdr[16]
                         ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];

    // Only valid while the ECC byte itself is on data.
    assign w_syndrome = w_ecc_calc ^ data[5:0];
    assign w_hdr_ok   = (w_syndrome == 6'd0) || !CHECK_ECC;
    assign w_short    = (r_b0[5:4] == 2'b00);
    assign w_wc       = {r_b2, r_b1};
    assign w_crc_next = crc16_byte(r_crc, data);

    always_ff @(posedge clock_p or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= 2'd0;
            r_b0            <= 8'd0;
            r_b1            <= 8'd0;
            r_b2            <= 8'd0;
            r_cnt           <= 16'd0;
            r_crc           <= 16'd0;
            r_crc_lo        <= 8'd0;
            r_ftr_idx       <= 1'b0;
            phy_reset       <= 1'b0;
            virtual_channel <= 2'd0;
            data_type       <= 6'd0;
            word_count      <= 16'd0;
            header_valid    <= 1'b0;
            ecc_error       <= 1'b0;
            frame_start     <= 1'b0;
            frame_end       <= 1'b0;
            line_start      <= 1'b0;
            line_end        <= 1'b0;
            payload_data    <= 8'd0;
            payload_valid   <= 1'b0;
            payload_last    <= 1'b0;
            crc_error       <= 1'b0;
        end else begin
            phy_reset     <= 1'b0;
            header_valid  <= 1'b0;
            ecc_error     <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            crc_error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_b0    <= data;
                        r_idx   <= 2'd1;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (enable) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd1) begin
                            r_b1 <= data;
                        end else if (r_idx == 2'd2) begin
                            r_b2 <= data;
                        end else begin
                            virtual_channel <= r_b0[7:6];
                            data_type       <= r_b0[5:0];
                            word_count      <= w_wc;
                            ecc_error       <= (w_syndrome != 6'd0);
                            header_valid    <= w_hdr_ok;
                            frame_start     <= w_hdr_ok && (r_b0[5:0] == 6'h00);
                            frame_end       <= w_hdr_ok && (r_b0[5:0] == 6'h01);
                            line_start      <= w_hdr_ok && (r_b0[5:0] == 6'h02);
                            line_end        <= w_hdr_ok && (r_b0[5:0] == 6'h03);
                            r_crc           <= 16'hFFFF;
                            r_cnt           <= w_wc;
                            r_ftr_idx       <= 1'b0;
                            if (!w_hdr_ok || w_short)
                                r_state <= S_FLUSH;
                            else if (w_wc != 16'd0)
                                r_state <= S_PAYLOAD;
                            else
                                r_state <= S_FOOTER;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (enable) begin
                        payload_data  <= data;
                        payload_valid <= 1'b1;
                        r_crc         <= w_crc_next;
                        r_cnt         <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            payload_last <= 1'b1;
                            r_state      <= S_FOOTER;
                        end
                    end
                end
                S_FOOTER: begin
                    if (enable) begin
                        if (!r_ftr_idx) begin
                            r_crc_lo  <= data;
                            r_ftr_idx <= 1'b1;
                        end else begin
                            crc_error <= CHECK_CRC && ({data, r_crc_lo} != r_crc);
                            r_state   <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    phy_reset <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi_packet_parser.sv
// Directed bench for csi_packet_parser: short, ECC-error, long and reset-abort packets.
module tb_csi_packet_parser;

    logic        clock_p = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  data    = 8'd0;
    logic        enable  = 1'b0;
    logic        phy_reset;
    logic [1:0]  virtual_channel;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic        header_valid, ecc_error;
    logic        frame_start, frame_end, line_start, line_end;
    logic [7:0]  payload_data;
    logic        payload_valid, payload_last, crc_error;

    int errors = 0;
    int checks = 0;
    int n_phy  = 0;
    int n_pv   = 0;

    csi_packet_parser dut (
        .clock_p(clock_p), .reset(reset), .data(data), .enable(enable),
        .phy_reset(phy_reset), .virtual_channel(virtual_channel), .data_type(data_type),
        .word_count(word_count), .header_valid(header_valid), .ecc_error(ecc_error),
        .frame_start(frame_start), .frame_end(frame_end), .line_start(line_start),
        .line_end(line_end), .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_last(payload_last), .crc_error(crc_error)
    );

    always #5 clock_p = ~clock_p;

    always @(negedge clock_p) begin
        if (phy_reset) n_phy++;
        if (payload_valid) n_pv++;
    end

    function automatic logic [41:0] all_outs();
        return {phy_reset, virtual_channel, data_type, word_count, header_valid, ecc_error,
                frame_start, frame_end, line_start, line_end, payload_data, payload_valid,
                payload_last, crc_error};
    endfunction

    // Reference CRC: classic reflected CCITT table-less loop with mask 0x8408.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 16'h8408;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    // Respects the 1-in-4 byte spacing; returns 1ns after the consuming edge.
    task automatic send_byte(input logic [7:0] b);
        repeat (3) @(posedge clock_p);
        #1 data = b; enable = 1'b1;
        @(posedge clock_p);
        #1 enable = 1'b0; data = 8'd0;
    endtask

    task automatic next_cycle();
        @(posedge clock_p);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock_p);
        #1;
        checks++; if (all_outs() !== 42'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", all_outs()); end
        reset = 1'b0;
    endtask

    task automatic test_frame_start();
        int p0;
        p0 = n_phy;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++; if (header_valid !== 1'b1) begin errors++; $display("FAIL fs_header_valid got=%b exp=1", header_valid); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_frame_start got=%b exp=1", frame_start); end
        checks++; if (ecc_error !== 1'b0) begin errors++; $display("FAIL fs_ecc_error got=%b exp=0", ecc_error); end
        checks++; if ({virtual_channel, data_type, word_count} !== 24'd0) begin errors++; $display("FAIL fs_fields got=%h exp=0", {virtual_channel, data_type, word_count}); end
        checks++; if (phy_reset !== 1'b0) begin errors++; $display("FAIL fs_phy_early got=%b exp=0", phy_reset); end
        next_cycle();
        checks++; if ({phy_reset, header_valid, frame_start} !== 3'b100) begin errors++; $display("FAIL fs_phy_pulse got=%b exp=100", {phy_reset, header_valid, frame_start}); end
        next_cycle();
        checks++; if (phy_reset !== 1'b0) begin errors++; $display("FAIL fs_phy_one_cycle got=%b exp=0", phy_reset); end
        checks++; if (n_phy - p0 !== 1) begin errors++; $display("FAIL fs_phy_count got=%0d exp=1", n_phy - p0); end
    endtask

    task automatic test_ecc_error();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        checks++; if (ecc_error !== 1'b1) begin errors++; $display("FAIL ecc_flag got=%b exp=1", ecc_error); end
        checks++; if ({header_valid, frame_start} !== 2'b00) begin errors++; $display("FAIL ecc_suppress got=%b exp=00", {header_valid, frame_start}); end
        next_cycle();
        checks++; if ({phy_reset, ecc_error} !== 2'b10) begin errors++; $display("FAIL ecc_phy_pulse got=%b exp=10", {phy_reset, ecc_error}); end
        next_cycle();
    endtask

    task automatic test_line_start();
        // DI=0x42 (VC=1, DT=0x02), WC=0x1234, ECC=0x1C.
        send_byte(8'h42); send_byte(8'h34); send_byte(8'h12); send_byte(8'h1C);
        checks++; if ({header_valid, ecc_error, line_start, frame_start, line_end} !== 5'b10100) begin errors++; $display("FAIL ls_pulses got=%b exp=10100", {header_valid, ecc_error, line_start, frame_start, line_end}); end
        checks++; if ({virtual_channel, data_type, word_count} !== {2'd1, 6'h02, 16'h1234}) begin errors++; $display("FAIL ls_fields got=%h exp=%h", {virtual_channel, data_type, word_count}, {2'd1, 6'h02, 16'h1234}); end
        next_cycle();
        checks++; if (phy_reset !== 1'b1) begin errors++; $display("FAIL ls_phy got=%b exp=1", phy_reset); end
        next_cycle();
    endtask

    task automatic test_long_wc0();
        int pv0, p0;
        pv0 = n_pv; p0 = n_phy;
        send_byte(8'h2A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        checks++; if ({header_valid, ecc_error} !== 2'b10) begin errors++; $display("FAIL wc0_header got=%b exp=10", {header_valid, ecc_error}); end
        checks++; if ({data_type, word_count} !== {6'h2A, 16'h0000}) begin errors++; $display("FAIL wc0_fields got=%h exp=%h", {data_type, word_count}, {6'h2A, 16'h0000}); end
        send_byte(8'hFF);
        checks++; if (phy_reset !== 1'b0) begin errors++; $display("FAIL wc0_phy_early got=%b exp=0", phy_reset); end
        send_byte(8'hFF);
        checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL wc0_crc got=%b exp=0", crc_error); end
        next_cycle();
        checks++; if (phy_reset !== 1'b1) begin errors++; $display("FAIL wc0_phy got=%b exp=1", phy_reset); end
        next_cycle();
        checks++; if (n_pv - pv0 !== 0) begin errors++; $display("FAIL wc0_no_payload got=%0d exp=0", n_pv - pv0); end
        checks++; if (n_phy - p0 !== 1) begin errors++; $display("FAIL wc0_phy_count got=%0d exp=1", n_phy - p0); end
    endtask

    task automatic test_long_payload(input logic corrupt);
        logic [7:0]  pl [4];
        logic [15:0] crc;
        int p0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        crc = 16'hFFFF;
        for (int i = 0; i < 4; i++) crc = crc_ref(crc, pl[i]);
        p0 = n_phy;
        send_byte(8'h2A); send_byte(8'h04); send_byte(8'h00); send_byte(8'h33);
        checks++; if ({header_valid, ecc_error, word_count} !== {2'b10, 16'd4}) begin errors++; $display("FAIL pl_header got=%h exp=%h", {header_valid, ecc_error, word_count}, {2'b10, 16'd4}); end
        for (int i = 0; i < 4; i++) begin
            send_byte(pl[i]);
            checks++;
            if ({payload_valid, payload_data, payload_last} !== {1'b1, pl[i], (i == 3)}) begin
                errors++;
                $display("FAIL pl_byte%0d got=%h exp=%h", i, {payload_valid, payload_data, payload_last}, {1'b1, pl[i], (i == 3)});
            end
        end
        send_byte(crc[7:0] ^ {7'd0, corrupt});
        send_byte(crc[15:8]);
        checks++; if (crc_error !== corrupt) begin errors++; $display("FAIL pl_crc_error got=%b exp=%b", crc_error, corrupt); end
        next_cycle();
        checks++; if ({phy_reset, crc_error} !== 2'b10) begin errors++; $display("FAIL pl_phy got=%b exp=10", {phy_reset, crc_error}); end
        next_cycle();
        checks++; if (n_phy - p0 !== 1) begin errors++; $display("FAIL pl_phy_count got=%0d exp=1", n_phy - p0); end
    endtask

    task automatic test_async_reset();
        int p0;
        p0 = n_phy;
        send_byte(8'h2A); send_byte(8'h04); send_byte(8'h00); send_byte(8'h33);
        send_byte(8'h11); send_byte(8'h22);
        checks++; if ({payload_valid, payload_data} !== 9'h122) begin errors++; $display("FAIL ar_pre got=%h exp=122", {payload_valid, payload_data}); end
        #1 reset = 1'b1;
        #1;
        checks++; if (all_outs() !== 42'd0) begin errors++; $display("FAIL ar_outputs got=%h exp=0", all_outs()); end
        repeat (3) @(posedge clock_p);
        #1 reset = 1'b0;
        repeat (3) next_cycle();
        checks++; if (n_phy - p0 !== 0) begin errors++; $display("FAIL ar_no_phy got=%0d exp=0", n_phy - p0); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++; if ({header_valid, frame_start, ecc_error} !== 3'b110) begin errors++; $display("FAIL ar_recover got=%b exp=110", {header_valid, frame_start, ecc_error}); end
        next_cycle();
        checks++; if (phy_reset !== 1'b1) begin errors++; $display("FAIL ar_recover_phy got=%b exp=1", phy_reset); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_ecc_error();
        test_line_start();
        test_long_wc0();
        test_long_payload(1'b0);
        test_long_payload(1'b1);
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
